// File: rtl/onehot_codec.sv
// onehot_codec: registered one-hot <-> binary code converters.
// The encoder turns a one-hot (or multi-hot) vector into the index of its
// highest set bit and flags zero and multi-hot inputs. The decoder turns an
// index back into a one-hot enable vector. The two paths share only the
// clock and reset, and each has a latency of one cycle.
module onehot_codec #(
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<SEL_W)-1:0] enc_in,
  input  logic                  enc_in_vld,
  output logic [SEL_W-1:0]      enc_out,
  output logic                  enc_out_vld,
  output logic                  enc_multi,
  output logic                  enc_zero,
  input  logic [SEL_W-1:0]      dec_in,
  input  logic                  dec_in_vld,
  input  logic                  dec_en,
  output logic [(1<<SEL_W)-1:0] dec_out,
  output logic                  dec_out_vld
);

  localparam int OH_W = 1 << SEL_W;

  // Encoder registered state and combinational next values
  logic [SEL_W-1:0] enc_idx_next;
  logic             enc_any_next;
  logic             enc_multi_next;
  logic [SEL_W-1:0] enc_out_reg;
  logic             enc_out_vld_reg;
  logic             enc_multi_reg;
  logic             enc_zero_reg;

  // Decoder registered state and combinational next value
  logic [OH_W-1:0]  dec_onehot_next;
  logic [OH_W-1:0]  dec_out_reg;
  logic             dec_out_vld_reg;

  // Priority encode: scanning upward lets the highest set bit win.
  always_comb begin
    enc_idx_next = '0;
    for (int i = 0; i < OH_W; i++) begin
      if (enc_in[i]) begin
        enc_idx_next = SEL_W'(i);
      end
    end
  end

  // Zero / multi-hot detection; clearing the lowest set bit leaves
  // something behind only if two or more bits were set.
  always_comb begin
    enc_any_next   = |enc_in;
    enc_multi_next = |(enc_in & (enc_in - OH_W'(1)));
  end

  // Decoder: one comparator per output line.
  generate
    for (genvar gi = 0; gi < OH_W; gi++) begin : g_dec
      assign dec_onehot_next[gi] = (dec_in == SEL_W'(gi));
    end
  endgenerate

  // Encoder registers: index holds when no valid input, flags clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_out_reg     <= '0;
      enc_out_vld_reg <= 1'b0;
      enc_multi_reg   <= 1'b0;
      enc_zero_reg    <= 1'b0;
    end else if (enc_in_vld) begin
      enc_out_reg     <= enc_any_next ? enc_idx_next : '0;
      enc_out_vld_reg <= enc_any_next;
      enc_multi_reg   <= enc_multi_next;
      enc_zero_reg    <= ~enc_any_next;
    end else begin
      enc_out_vld_reg <= 1'b0;
      enc_multi_reg   <= 1'b0;
      enc_zero_reg    <= 1'b0;
    end
  end

  // Decoder registers: enables never outlive their valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_out_reg     <= '0;
      dec_out_vld_reg <= 1'b0;
    end else begin
      dec_out_vld_reg <= dec_in_vld;
      dec_out_reg     <= (dec_in_vld && dec_en) ? dec_onehot_next : '0;
    end
  end

  assign enc_out     = enc_out_reg;
  assign enc_out_vld = enc_out_vld_reg;
  assign enc_multi   = enc_multi_reg;
  assign enc_zero    = enc_zero_reg;
  assign dec_out     = dec_out_reg;
  assign dec_out_vld = dec_out_vld_reg;

endmodule

// File: tb/tb_onehot_codec.sv
// Directed self-checking bench for onehot_codec in its default
// configuration (4-bit one-hot, 2-bit index).
module tb_onehot_codec;

  localparam int SEL_W = 2;
  localparam int OH_W  = 1 << SEL_W;

  logic             clk;
  logic             rst;
  logic [OH_W-1:0]  enc_in;
  logic             enc_in_vld;
  logic [SEL_W-1:0] enc_out;
  logic             enc_out_vld;
  logic             enc_multi;
  logic             enc_zero;
  logic [SEL_W-1:0] dec_in;
  logic             dec_in_vld;
  logic             dec_en;
  logic [OH_W-1:0]  dec_out;
  logic             dec_out_vld;

  int vec_cnt;
  int err_cnt;

  onehot_codec #(.SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_in      (enc_in),
    .enc_in_vld  (enc_in_vld),
    .enc_out     (enc_out),
    .enc_out_vld (enc_out_vld),
    .enc_multi   (enc_multi),
    .enc_zero    (enc_zero),
    .dec_in      (dec_in),
    .dec_in_vld  (dec_in_vld),
    .dec_en      (dec_en),
    .dec_out     (dec_out),
    .dec_out_vld (dec_out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report one line either way.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoder outputs packed as {vld, multi, zero, out[1:0]}
  function automatic logic [31:0] enc_pack();
    return {27'd0, enc_out_vld, enc_multi, enc_zero, enc_out};
  endfunction

  // Decoder outputs packed as {vld, out[3:0]}
  function automatic logic [31:0] dec_pack();
    return {27'd0, dec_out_vld, dec_out};
  endfunction

  logic [3:0] msb_exp;
  logic [1:0] idx_exp;
  logic [3:0] v;

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b1;
    enc_in     = 4'b1000;
    enc_in_vld = 1'b1;
    dec_in     = 2'b11;
    dec_in_vld = 1'b1;
    dec_en     = 1'b1;
    #2;

    // Reset held two cycles with valid traffic present
    tick();
    chk("rst1_enc", enc_pack(), 32'h00);
    chk("rst1_dec", dec_pack(), 32'h00);
    tick();
    chk("rst2_enc", enc_pack(), 32'h00);
    chk("rst2_dec", dec_pack(), 32'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_enc", enc_pack(), {27'd0, 1'b1, 1'b0, 1'b0, 2'b11});
    chk("post_rst_dec", dec_pack(), {27'd0, 1'b1, 4'b1000});

    // Encoder sweep over single-hot inputs
    dec_in_vld = 1'b0;
    enc_in = 4'b0001; tick(); chk("enc_0001", enc_pack(), 32'h10);
    enc_in = 4'b0010; tick(); chk("enc_0010", enc_pack(), 32'h11);
    enc_in = 4'b0100; tick(); chk("enc_0100", enc_pack(), 32'h12);
    enc_in = 4'b1000; tick(); chk("enc_1000", enc_pack(), 32'h13);

    // Encoder corner cases
    enc_in = 4'b0000; tick(); chk("enc_zero", enc_pack(), 32'h04);
    enc_in = 4'b1010; tick(); chk("enc_1010", enc_pack(), 32'h1B);
    enc_in = 4'b0110; tick(); chk("enc_0110", enc_pack(), 32'h1A);
    enc_in_vld = 1'b0; enc_in = 4'b0001;
    tick(); chk("enc_hold", enc_pack(), 32'h02);
    tick(); chk("enc_hold2", enc_pack(), 32'h02);
    chk("dec_idle", dec_pack(), 32'h00);

    // Decoder sweep
    dec_in_vld = 1'b1; dec_en = 1'b1;
    dec_in = 2'b00; tick(); chk("dec_00", dec_pack(), 32'h11);
    dec_in = 2'b01; tick(); chk("dec_01", dec_pack(), 32'h12);
    dec_in = 2'b10; tick(); chk("dec_10", dec_pack(), 32'h14);
    dec_in = 2'b11; tick(); chk("dec_11", dec_pack(), 32'h18);
    dec_en = 1'b0; dec_in = 2'b10;
    tick(); chk("dec_dis", dec_pack(), 32'h10);
    dec_in_vld = 1'b0; dec_en = 1'b1;
    tick(); chk("dec_novld", dec_pack(), 32'h00);

    // Loopback: encode, then feed the index back into the decoder
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      msb_exp = 4'b0000;
      idx_exp = 2'b00;
      for (int b = 0; b < 4; b++) begin
        if (v[b]) begin
          msb_exp = 4'b0001 << b;
          idx_exp = 2'(b);
        end
      end
      enc_in = v; enc_in_vld = 1'b1; dec_in_vld = 1'b0;
      tick();
      chk($sformatf("lb_enc_%0h", i), {30'd0, enc_out}, {30'd0, idx_exp});
      enc_in_vld = 1'b0;
      dec_in = enc_out; dec_in_vld = (v != 4'b0000);
      tick();
      chk($sformatf("lb_dec_%0h", i), {28'd0, dec_out}, {28'd0, msb_exp});
    end
    dec_in_vld = 1'b0;

    // Reset pulse in the middle of traffic on both paths
    enc_in = 4'b0100; enc_in_vld = 1'b1;
    dec_in = 2'b01;   dec_in_vld = 1'b1; dec_en = 1'b1;
    tick();
    chk("mid_pre_enc", enc_pack(), 32'h12);
    chk("mid_pre_dec", dec_pack(), 32'h12);
    rst = 1'b1; enc_in = 4'b0001; dec_in = 2'b10;
    tick();
    chk("mid_rst_enc", enc_pack(), 32'h00);
    chk("mid_rst_dec", dec_pack(), 32'h00);
    rst = 1'b0;
    tick();
    chk("mid_post_enc", enc_pack(), 32'h10);
    chk("mid_post_dec", dec_pack(), 32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
